// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the MCMC engine (A) and host (B).
// Optional ownership lock for atomic read-modify-write: define BRAM_ARB_LOCK_EN.
module bram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_we,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
`ifdef BRAM_ARB_LOCK_EN
    input  logic                a_lock,
    input  logic                b_lock,
`endif
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    output logic [DATA_W/8-1:0] bram_we,
    output logic                bram_en,
    output logic                bram_rst,
    input  logic [DATA_W-1:0]   bram_dout
);

    logic                last_b;
    logic                a_ok;
    logic                b_ok;
    logic                rd_push;
    logic [RD_LAT-1:0]   tag_vld;
    logic [RD_LAT-1:0]   tag_own;

`ifdef BRAM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } lock_state_t;

    lock_state_t state;
    lock_state_t state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (a_gnt && a_lock) begin
                    state_nxt = LOCK_A;
                end else if (b_gnt && b_lock) begin
                    state_nxt = LOCK_B;
                end
            end
            LOCK_A: begin
                if ((a_gnt || !a_req) && !a_lock) begin
                    state_nxt = IDLE;
                end
            end
            LOCK_B: begin
                if ((b_gnt || !b_req) && !b_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The owner of a lock shuts the other requester out entirely.
    always_comb begin
        a_ok = a_req && rst && (state != LOCK_B);
        b_ok = b_req && rst && (state != LOCK_A);
    end
`else
    always_comb begin
        a_ok = a_req && rst;
        b_ok = b_req && rst;
    end
`endif

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        a_gnt = a_ok && (!b_ok || last_b);
        b_gnt = b_ok && !a_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b <= 1'b1;
        end else if (a_gnt) begin
            last_b <= 1'b0;
        end else if (b_gnt) begin
            last_b <= 1'b1;
        end
    end

    always_comb begin
        bram_en   = a_gnt || b_gnt;
        bram_addr = b_gnt ? b_addr : a_addr;
        bram_din  = b_gnt ? b_wdata : a_wdata;
        bram_we   = '0;
        if (a_gnt) begin
            bram_we = a_we;
        end else if (b_gnt) begin
            bram_we = b_we;
        end
        bram_rst  = 1'b0;
    end

    assign rd_push = (a_gnt && (a_we == '0)) || (b_gnt && (b_we == '0));

    // Tag pipeline mirrors BRAM read latency so returns follow grant order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
            tag_vld[0] <= rd_push;
            tag_own[0] <= b_gnt;
        end
    end

    always_comb begin
        a_rvalid = tag_vld[RD_LAT-1] && !tag_own[RD_LAT-1];
        b_rvalid = tag_vld[RD_LAT-1] && tag_own[RD_LAT-1];
        a_rdata  = bram_dout;
        b_rdata  = bram_dout;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1 and one with RD_LAT=2 share stimulus,
// each behind its own BRAM model.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req;
    logic [31:0] a_addr;
    logic [7:0]  a_we;
    logic [63:0] a_wdata;
    logic        b_req;
    logic [31:0] b_addr;
    logic [7:0]  b_we;
    logic [63:0] b_wdata;
`ifdef BRAM_ARB_LOCK_EN
    logic        a_lock;
    logic        b_lock;
`endif

    logic        a_gnt1, b_gnt1, a_rv1, b_rv1, en1, brst1;
    logic [63:0] a_rd1, b_rd1, din1, dout1;
    logic [31:0] addr1;
    logic [7:0]  we1;
    logic        a_gnt2, b_gnt2, a_rv2, b_rv2, en2, brst2;
    logic [63:0] a_rd2, b_rd2, din2, dout2;
    logic [31:0] addr2;
    logic [7:0]  we2;

    int n_cmp;
    int n_err;

    logic [63:0] mem1 [0:127];
    logic [63:0] mem2 [0:127];
    logic [63:0] rd1;
    logic [63:0] rd2a;
    logic [63:0] rd2b;

    bram_port_arbiter #(.ADDR_W(32), .DATA_W(64), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
`ifdef BRAM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .bram_addr(addr1), .bram_din(din1), .bram_we(we1),
        .bram_en(en1), .bram_rst(brst1), .bram_dout(dout1)
    );

    bram_port_arbiter #(.ADDR_W(32), .DATA_W(64), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_gnt(a_gnt2), .a_rvalid(a_rv2), .a_rdata(a_rd2),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_gnt(b_gnt2), .b_rvalid(b_rv2), .b_rdata(b_rd2),
`ifdef BRAM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .bram_addr(addr2), .bram_din(din2), .bram_we(we2),
        .bram_en(en2), .bram_rst(brst2), .bram_dout(dout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (en1) begin
            for (int i = 0; i < 8; i++) begin
                if (we1[i]) mem1[addr1[9:3]][8*i +: 8] <= din1[8*i +: 8];
            end
            rd1 <= mem1[addr1[9:3]];
        end
    end
    assign dout1 = rd1;

    always @(posedge clk) begin
        if (en2) begin
            for (int i = 0; i < 8; i++) begin
                if (we2[i]) mem2[addr2[9:3]][8*i +: 8] <= din2[8*i +: 8];
            end
            rd2a <= mem2[addr2[9:3]];
        end
        rd2b <= rd2a;
    end
    assign dout2 = rd2b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic [31:0] ad,
                         input logic [7:0] w, input logic [63:0] d);
        a_req = r; a_addr = ad; a_we = w; a_wdata = d;
    endtask

    task automatic set_b(input logic r, input logic [31:0] ad,
                         input logic [7:0] w, input logic [63:0] d);
        b_req = r; b_addr = ad; b_we = w; b_wdata = d;
    endtask

    task automatic test_reset();
        set_a(1'b1, 32'h10, 8'hFF, 64'h1);
        set_b(1'b1, 32'h18, 8'h00, 64'h0);
        repeat (8) begin
            @(negedge clk);
            n_cmp++;
            if ({a_gnt1, b_gnt1, a_rv1, b_rv1, en1, we1, brst1,
                 a_gnt2, b_gnt2, a_rv2, b_rv2, en2, we2, brst2} !== 28'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got gnt1=%b%b rv1=%b%b en1=%b we1=%h gnt2=%b%b rv2=%b%b en2=%b we2=%h, want all 0",
                         a_gnt1, b_gnt1, a_rv1, b_rv1, en1, we1,
                         a_gnt2, b_gnt2, a_rv2, b_rv2, en2, we2);
            end
        end
        tick();
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        set_b(1'b0, 32'h0, 8'h00, 64'h0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        logic        ea;
        logic [31:0] eaddr;
        set_a(1'b1, 32'h40, 8'h00, 64'h0);
        set_b(1'b1, 32'h48, 8'h00, 64'h0);
        for (int i = 0; i < 6; i++) begin
            ea = (i % 2) == 0;
            eaddr = ea ? 32'h40 : 32'h48;
            @(negedge clk);
            n_cmp++;
            if ({a_gnt1, b_gnt1, en1} !== {ea, !ea, 1'b1}) begin
                n_err++;
                $display("FAIL fair_gnt1[%0d]: got a=%b b=%b en=%b, want a=%b b=%b en=1",
                         i, a_gnt1, b_gnt1, en1, ea, !ea);
            end
            n_cmp++;
            if ({a_gnt2, b_gnt2, en2} !== {ea, !ea, 1'b1}) begin
                n_err++;
                $display("FAIL fair_gnt2[%0d]: got a=%b b=%b en=%b, want a=%b b=%b en=1",
                         i, a_gnt2, b_gnt2, en2, ea, !ea);
            end
            n_cmp++;
            if (addr1 !== eaddr) begin
                n_err++;
                $display("FAIL fair_addr[%0d]: got %h, want %h", i, addr1, eaddr);
            end
            tick();
        end
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        set_b(1'b0, 32'h0, 8'h00, 64'h0);
        repeat (3) tick();
    endtask

    task automatic test_single();
        set_a(1'b1, 32'h10, 8'hFF, 64'h1122334455667788);
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, b_gnt1, en1, we1} !== {3'b101, 8'hFF} || din1 !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL single_write: got gnt=%b%b en=%b we=%h din=%h, want 10 1 ff 1122334455667788",
                     a_gnt1, b_gnt1, en1, we1, din1);
        end
        tick();
        set_a(1'b1, 32'h10, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, en1, we1} !== {2'b11, 8'h00}) begin
            n_err++;
            $display("FAIL single_read_gnt: got gnt=%b en=%b we=%h, want 1 1 00", a_gnt1, en1, we1);
        end
        tick();
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b1000 || a_rd1 !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL single_ret_lat1: got rv1=%b%b rv2=%b%b data=%h, want 10 00 1122334455667788",
                     a_rv1, b_rv1, a_rv2, b_rv2, a_rd1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({a_rv1, b_rv1, a_rv2, b_rv2} !== 4'b0010 || a_rd2 !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL single_ret_lat2: got rv1=%b%b rv2=%b%b data=%h, want 00 10 1122334455667788",
                     a_rv1, b_rv1, a_rv2, b_rv2, a_rd2);
        end
        tick();
    endtask

    task automatic test_routing();
        logic [1:0]  ge  [5];
        logic [1:0]  e1  [5];
        logic [1:0]  e2  [5];
        logic [63:0] d1  [5];
        logic [63:0] d2  [5];
        ge = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        e1 = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
        e2 = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        d1 = '{64'h0, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 64'h1122334455667788, 64'h0};
        d2 = '{64'h0, 64'h0, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 64'h1122334455667788};
        set_a(1'b1, 32'h0, 8'hFF, 64'hA0A1A2A3A4A5A6A7);
        tick();
        set_a(1'b1, 32'h8, 8'hFF, 64'hB0B1B2B3B4B5B6B7);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_a(c == 0 || c == 2, (c == 0) ? 32'h0 : 32'h10, 8'h00, 64'h0);
            set_b(c == 1, 32'h8, 8'h00, 64'h0);
            @(negedge clk);
            n_cmp++;
            if ({a_gnt2, b_gnt2} !== ge[c]) begin
                n_err++;
                $display("FAIL route_gnt[%0d]: got %b%b, want %b", c, a_gnt2, b_gnt2, ge[c]);
            end
            n_cmp++;
            if ({a_rv1, b_rv1} !== e1[c] || (e1[c][1] && a_rd1 !== d1[c]) ||
                (e1[c][0] && b_rd1 !== d1[c])) begin
                n_err++;
                $display("FAIL route_lat1[%0d]: got rv=%b%b data=%h, want rv=%b data=%h",
                         c, a_rv1, b_rv1, dout1, e1[c], d1[c]);
            end
            n_cmp++;
            if ({a_rv2, b_rv2} !== e2[c] || (e2[c][1] && a_rd2 !== d2[c]) ||
                (e2[c][0] && b_rd2 !== d2[c])) begin
                n_err++;
                $display("FAIL route_lat2[%0d]: got rv=%b%b data=%h, want rv=%b data=%h",
                         c, a_rv2, b_rv2, dout2, e2[c], d2[c]);
            end
            tick();
        end
    endtask

    task automatic test_merge();
        set_a(1'b1, 32'h18, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        tick();
        set_a(1'b1, 32'h18, 8'h0F, 64'h0123456789ABCDEF);
        @(negedge clk);
        n_cmp++;
        if (we1 !== 8'h0F || din1 !== 64'h0123456789ABCDEF) begin
            n_err++;
            $display("FAIL merge_drive: got we=%h din=%h, want 0f 0123456789abcdef", we1, din1);
        end
        tick();
        set_a(1'b1, 32'h18, 8'h00, 64'h0);
        tick();
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if (a_rv1 !== 1'b1 || a_rd1 !== 64'hFFFFFFFF89ABCDEF) begin
            n_err++;
            $display("FAIL merge_lat1: got rv=%b data=%h, want 1 ffffffff89abcdef", a_rv1, a_rd1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (a_rv2 !== 1'b1 || a_rd2 !== 64'hFFFFFFFF89ABCDEF) begin
            n_err++;
            $display("FAIL merge_lat2: got rv=%b data=%h, want 1 ffffffff89abcdef", a_rv2, a_rd2);
        end
        tick();
    endtask

`ifdef BRAM_ARB_LOCK_EN
    task automatic test_lock();
        set_b(1'b1, 32'h30, 8'h00, 64'h0);
        tick();
        set_b(1'b1, 32'h28, 8'h00, 64'h0);
        set_a(1'b1, 32'h20, 8'h00, 64'h0);
        a_lock = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, b_gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_rd: got %b%b, want 10", a_gnt1, b_gnt1);
        end
        tick();
        set_a(1'b1, 32'h20, 8'hFF, 64'h5);
        a_lock = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, b_gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_wr: got %b%b, want 10", a_gnt1, b_gnt1);
        end
        tick();
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, b_gnt1} !== 2'b01) begin
            n_err++;
            $display("FAIL lock_release: got %b%b, want 01", a_gnt1, b_gnt1);
        end
        tick();
        set_b(1'b0, 32'h0, 8'h00, 64'h0);
        repeat (3) tick();
    endtask
`endif

    task automatic test_reset_mid_read();
        set_a(1'b1, 32'h0, 8'h00, 64'h0);
        tick();
        rst = 1'b0;
        set_a(1'b1, 32'h0, 8'h00, 64'h0);
        set_b(1'b1, 32'h8, 8'h00, 64'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst = 1'b1;
                set_a(1'b0, 32'h0, 8'h00, 64'h0);
                set_b(1'b0, 32'h0, 8'h00, 64'h0);
            end
            @(negedge clk);
            n_cmp++;
            if ({a_rv1, b_rv1, a_rv2, b_rv2, a_gnt1, b_gnt1, a_gnt2, b_gnt2} !== 8'h00) begin
                n_err++;
                $display("FAIL midrst[%0d]: got rv1=%b%b rv2=%b%b gnt1=%b%b gnt2=%b%b, want all 0",
                         c, a_rv1, b_rv1, a_rv2, b_rv2, a_gnt1, b_gnt1, a_gnt2, b_gnt2);
            end
            tick();
        end
        set_a(1'b1, 32'h0, 8'h00, 64'h0);
        set_b(1'b1, 32'h8, 8'h00, 64'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_gnt1, b_gnt1, a_gnt2, b_gnt2} !== 4'b1010) begin
            n_err++;
            $display("FAIL midrst_tie: got gnt1=%b%b gnt2=%b%b, want 10 10",
                     a_gnt1, b_gnt1, a_gnt2, b_gnt2);
        end
        tick();
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        set_b(1'b0, 32'h0, 8'h00, 64'h0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        set_a(1'b0, 32'h0, 8'h00, 64'h0);
        set_b(1'b0, 32'h0, 8'h00, 64'h0);
`ifdef BRAM_ARB_LOCK_EN
        a_lock = 1'b0;
        b_lock = 1'b0;
`endif
        #1;
        test_reset();
        test_fairness();
        test_single();
        test_routing();
        test_merge();
`ifdef BRAM_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single 64-bit BRAM port (address, din, dout, en, byte write-enable) between two requesters. Requester A is the MCMC update engine and requester B is the host/readback path. Each cycle, one access is granted with round-robin fairness, and read data is routed back to whichever requester issued the read. The block sits between the requesters and the BRAM instance, replacing a direct connection from the engine.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 64, data width; must be a multiple of 8.
- `RD_LAT`, 1, BRAM read latency in cycles; legal values 1..4.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  A access request; held with its payload until `a_gnt`.
- `a_addr`  in  ADDR_W  A address.
- `a_we`  in  DATA_W/8  A byte write-enables; 0 means read.
- `a_wdata`  in  DATA_W  A write data.
- `a_gnt`  out  1  A access accepted this cycle.
- `a_rvalid`  out  1  `a_rdata` holds A's read result.
- `a_rdata`  out  DATA_W  equals `bram_dout`.
- `b_req`, `b_addr`, `b_we`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as A, for requester B.
- `a_lock`, `b_lock`  in  1  hold ownership; present only with `BRAM_ARB_LOCK_EN`.
- `bram_addr`  out  ADDR_W  to BRAM.
- `bram_din`  out  DATA_W  to BRAM.
- `bram_we`  out  DATA_W/8  to BRAM.
- `bram_en`  out  1  to BRAM.
- `bram_rst`  out  1  tied to 0.
- `bram_dout`  in  DATA_W  from BRAM.

## Operation
- **Arbitration:** combinational each cycle.
  - Only one requester has `req` set: that requester is granted.
  - Both have `req` set: the requester not granted most recently wins.
  - The `last` pointer updates on every grant. Reset sets `last`=B, so A wins the first tie.
- **BRAM drive on a grant:** `bram_en`=1, and `bram_addr`/`bram_din`/`bram_we` are muxed from the winner. With no grant, `bram_en`=0 and `bram_we`=0; `bram_addr`/`bram_din` are don't-care.
- **Read tag pipeline:** RD_LAT deep, each stage holding {valid, owner}.
  - A granted access with `we`==0 pushes {1, owner}.
  - Writes and idle cycles push {0, x}.
  - The pipeline output drives `a_rvalid`/`b_rvalid`, which are mutually exclusive.
- **Writes** produce no rvalid. Partial `we` performs a byte-merge in the BRAM; the arbiter applies no masking.
- **Reset mid-operation:** asynchronous assertion clears the tag pipeline, so pending rvalids are dropped. It also clears `last` (to B) and the lock state. `gnt` is forced to 0 while `rst`=0.

## Timing
- **Reset values:** `a_gnt`, `b_gnt`, `a_rvalid`, `b_rvalid`, `bram_en`, `bram_we`, `bram_rst` = 0.
- **Grant latency:** 0 cycles. `gnt` is asserted in the same cycle as `req` when that requester wins. The payload is consumed at the end of that cycle.
- **Read latency:** a read granted in cycle N produces `rvalid` in cycle N+RD_LAT, with data valid in that same cycle.
- **Throughput:** one access per cycle. Back-to-back grants, including alternating owners, are legal. Read returns stay in grant order.
- **Handshake:** a requester may drop `req` only in a cycle after `gnt`. Changing the payload while `req`=1 and `gnt`=0 is illegal.

## Configuration
- **Macro: `BRAM_ARB_LOCK_EN`.**
- **Defined:** adds `a_lock`/`b_lock` and a 3-state lock FSM (IDLE, LOCK_A, LOCK_B) for atomic read-modify-write of spin words.
  - IDLE→LOCK_X: on a granted X access with `x_lock`=1.
  - In LOCK_X, only X may be granted; the other requester waits even if `last` favours it.
  - LOCK_X→IDLE: on a granted X access with `x_lock`=0, or in any cycle where `x_req`=0 and `x_lock`=0.
  - `last` keeps updating normally.
- **Undefined:** the lock ports and FSM are absent; the block is pure round-robin.

## Test plan
- **Reset:** hold `rst`=0 for 8 cycles while driving requests. Required: all gnt/rvalid/`bram_en`/`bram_we` = 0 throughout.
- **Single requester, RD_LAT=1:** A writes 0x1122334455667788 to 0x10 with `we`=0xFF, then reads 0x10. Required: `a_rvalid` one cycle after the read grant with that data, and `b_rvalid` stays 0.
- **Fairness:** `a_req` and `b_req` held high for 6 cycles. Required: grants go A,B,A,B,A,B, each with `bram_en`=1 and the matching address.
- **Routing, RD_LAT=2:** alternating reads A@0x0, B@0x8, A@0x10. Required: rvalids arrive 2 cycles later in the order A,B,A with the correct BRAM contents. Also: `we`=0x0F onto 0xFFFF…FF merges to 0xFFFFFFFF_<low wdata>.
- **Lock (macro on):** A reads 0x20 with `a_lock`=1 while `b_req`=1, then A writes with `a_lock`=0. Required: no `b_gnt` until the cycle after A's write grant.
- **Reset mid-read:** `rst` is asserted in the cycle after a read grant with RD_LAT=2. Required: no rvalid afterwards, and after release the first tie goes to A.
